ibex_trace_buffer: RTL and testbench

IBEX_TRACE_BUFFER -- requirements
Module: ibex_trace_buffer

---
 rtl/ibex_trace_buffer.sv | 162 ++++++++++++++++
 tb/tb_ibex_trace_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_trace_buffer.sv
// RVFI retirement trace buffer: stream FIFO or trigger-capture ring, drained via valid/ready.
// Optional feature macro: IBEX_TRACE_BUF_TIMESTAMP_EN appends mcycle[31:0] as the record MSBs.
module ibex_trace_buffer #(
  parameter int unsigned Depth    = 16,
  parameter bit          TrigMode = 1'b0,
  parameter int unsigned PostTrig = 4,
`ifdef IBEX_TRACE_BUF_TIMESTAMP_EN
  localparam int unsigned RecW    = 135
`else
  localparam int unsigned RecW    = 103
`endif
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       rvfi_valid_i,
  input  logic [31:0]                rvfi_pc_rdata_i,
  input  logic [31:0]                rvfi_insn_i,
  input  logic [4:0]                 rvfi_rd_addr_i,
  input  logic [31:0]                rvfi_rd_wdata_i,
  input  logic                       rvfi_trap_i,
  input  logic                       rvfi_intr_i,
  input  logic [63:0]                rvfi_ext_mcycle_i,
  input  logic                       enable_i,
  input  logic                       trig_i,
  input  logic                       clear_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [RecW-1:0]            out_data_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic [15:0]                overflow_cnt_o,
  output logic                       frozen_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {ARMED, POST, FROZEN} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [15:0]       ovf_q, ovf_d;
  logic [PtrW-1:0]   post_cnt_q, post_cnt_d;
  logic [RecW-1:0]   mem_q [Depth];

  logic [RecW-1:0]   rec_c;
  logic              push_att_c;
  logic              pop_c;
  logic              full_c;
  logic              we_c;
  logic              unused_mcycle;

  // Record packing; the pc field sits in the LSBs.
`ifdef IBEX_TRACE_BUF_TIMESTAMP_EN
  assign rec_c = {rvfi_ext_mcycle_i[31:0], rvfi_intr_i, rvfi_trap_i, rvfi_rd_addr_i,
                  rvfi_rd_wdata_i, rvfi_insn_i, rvfi_pc_rdata_i};
  assign unused_mcycle = ^rvfi_ext_mcycle_i[63:32];
`else
  assign rec_c = {rvfi_intr_i, rvfi_trap_i, rvfi_rd_addr_i,
                  rvfi_rd_wdata_i, rvfi_insn_i, rvfi_pc_rdata_i};
  assign unused_mcycle = ^rvfi_ext_mcycle_i;
`endif

  // Drain side: show-ahead head record; trigger mode only releases data once frozen.
  assign full_c         = (count_q == CntW'(Depth));
  assign out_valid_o    = TrigMode ? ((state_q == FROZEN) && (count_q != '0)) : (count_q != '0);
  assign out_data_o     = mem_q[rd_ptr_q];
  assign count_o        = count_q;
  assign overflow_cnt_o = ovf_q;
  assign frozen_o       = (state_q == FROZEN);

  assign push_att_c = rvfi_valid_i && enable_i && (state_q != FROZEN) && !clear_i;
  assign pop_c      = out_valid_o && out_ready_i && !clear_i;

  // Next-state: pointers, occupancy, overflow counter and capture FSM.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    post_cnt_d = post_cnt_q;
    we_c       = 1'b0;

    if (clear_i) begin
      state_d    = ARMED;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      ovf_d      = '0;
      post_cnt_d = '0;
    end else if (!TrigMode) begin
      if (pop_c) rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push_att_c) begin
        if (full_c && !pop_c) begin
          if (ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
        end else begin
          we_c     = 1'b1;
          wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
      end
      count_d = count_q + CntW'(we_c) - CntW'(pop_c);
    end else begin
      // Pushes never happen in FROZEN and pops only happen there, so they are exclusive.
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
        count_d  = count_q - CntW'(1);
      end
      if (push_att_c) begin
        we_c     = 1'b1;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (full_c) rd_ptr_d = rd_ptr_q + PtrW'(1);
        else        count_d  = count_q + CntW'(1);
      end
      case (state_q)
        ARMED: begin
          if (trig_i || (push_att_c && rvfi_trap_i)) begin
            if (PostTrig == 0) begin
              state_d = FROZEN;
            end else begin
              state_d    = POST;
              post_cnt_d = PtrW'(PostTrig);
            end
          end
        end
        POST: begin
          if (push_att_c) begin
            post_cnt_d = post_cnt_q - PtrW'(1);
            if (post_cnt_q == PtrW'(1)) state_d = FROZEN;
          end
        end
        default: ;
      endcase
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ARMED;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= '0;
      post_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      post_cnt_q <= post_cnt_d;
    end
  end

  // Record storage, not reset.
  always_ff @(posedge clk_i) begin
    if (we_c) mem_q[wr_ptr_q] <= rec_c;
  end

endmodule

// File: tb/tb_ibex_trace_buffer.sv
// Directed scoreboard bench for ibex_trace_buffer: one stream and two trigger-mode instances.
module tb_ibex_trace_buffer;

`ifdef IBEX_TRACE_BUF_TIMESTAMP_EN
  localparam int unsigned RecW = 135;
`else
  localparam int unsigned RecW = 103;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] pc, insn, wdata;
  logic [4:0]  rd;
  logic        trap, intr;
  logic [63:0] mcycle;

  logic s_en, s_trig, s_clr, s_rdy, s_valid, s_frozen;
  logic [RecW-1:0] s_data;
  logic [2:0]  s_count;
  logic [15:0] s_ovf;

  logic t8_en, t8_trig, t8_clr, t8_rdy, t8_valid, t8_frozen;
  logic [RecW-1:0] t8_data;
  logic [3:0]  t8_count;
  logic [15:0] t8_ovf;

  logic t0_en, t0_trig, t0_clr, t0_rdy, t0_valid, t0_frozen;
  logic [RecW-1:0] t0_data;
  logic [2:0]  t0_count;
  logic [15:0] t0_ovf;

  int checks = 0;
  int errors = 0;
  logic [102:0] exp_q[$];
  logic [102:0] e;

  always #5 clk = ~clk;

  ibex_trace_buffer #(.Depth(4), .TrigMode(1'b0), .PostTrig(0)) u_s (
    .clk_i(clk), .rst_i(rst), .rvfi_valid_i(valid), .rvfi_pc_rdata_i(pc), .rvfi_insn_i(insn),
    .rvfi_rd_addr_i(rd), .rvfi_rd_wdata_i(wdata), .rvfi_trap_i(trap), .rvfi_intr_i(intr),
    .rvfi_ext_mcycle_i(mcycle), .enable_i(s_en), .trig_i(s_trig), .clear_i(s_clr),
    .out_valid_o(s_valid), .out_ready_i(s_rdy), .out_data_o(s_data), .count_o(s_count),
    .overflow_cnt_o(s_ovf), .frozen_o(s_frozen));

  ibex_trace_buffer #(.Depth(8), .TrigMode(1'b1), .PostTrig(2)) u_t8 (
    .clk_i(clk), .rst_i(rst), .rvfi_valid_i(valid), .rvfi_pc_rdata_i(pc), .rvfi_insn_i(insn),
    .rvfi_rd_addr_i(rd), .rvfi_rd_wdata_i(wdata), .rvfi_trap_i(trap), .rvfi_intr_i(intr),
    .rvfi_ext_mcycle_i(mcycle), .enable_i(t8_en), .trig_i(t8_trig), .clear_i(t8_clr),
    .out_valid_o(t8_valid), .out_ready_i(t8_rdy), .out_data_o(t8_data), .count_o(t8_count),
    .overflow_cnt_o(t8_ovf), .frozen_o(t8_frozen));

  ibex_trace_buffer #(.Depth(4), .TrigMode(1'b1), .PostTrig(0)) u_t0 (
    .clk_i(clk), .rst_i(rst), .rvfi_valid_i(valid), .rvfi_pc_rdata_i(pc), .rvfi_insn_i(insn),
    .rvfi_rd_addr_i(rd), .rvfi_rd_wdata_i(wdata), .rvfi_trap_i(trap), .rvfi_intr_i(intr),
    .rvfi_ext_mcycle_i(mcycle), .enable_i(t0_en), .trig_i(t0_trig), .clear_i(t0_clr),
    .out_valid_o(t0_valid), .out_ready_i(t0_rdy), .out_data_o(t0_data), .count_o(t0_count),
    .overflow_cnt_o(t0_ovf), .frozen_o(t0_frozen));

  function automatic logic [102:0] mkrec(input int i, input bit tr);
    logic [31:0] p;
    p = 32'h100 + 32'(4 * i);
    return {i[0], tr, 5'(i), ~p, 32'h13 ^ 32'(i), p};
  endfunction

  task automatic set_rec(input int i, input bit tr);
    logic [102:0] r;
    r = mkrec(i, tr);
    {intr, trap, rd, wdata, insn, pc} = r;
    mcycle = 64'(i) * 64'd3;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drain one instance (0 = stream, 1 = trig depth 8, 2 = trig posttrig 0) against the scoreboard.
  task automatic drain(input int which);
    logic            v;
    logic [RecW-1:0] d;
    case (which)
      0: s_rdy = 1'b1;
      1: t8_rdy = 1'b1;
      default: t0_rdy = 1'b1;
    endcase
    for (int k = 0; k < 32 && exp_q.size() > 0; k++) begin
      case (which)
        0: begin v = s_valid; d = s_data; end
        1: begin v = t8_valid; d = t8_data; end
        default: begin v = t0_valid; d = t0_data; end
      endcase
      chk("drain_valid", 136'(v), 136'(1'b1));
      chk("drain_data", 136'(d[102:0]), 136'(exp_q.pop_front()));
      step();
    end
    s_rdy = 1'b0; t8_rdy = 1'b0; t0_rdy = 1'b0;
    chk("drain_left", 136'(exp_q.size()), 136'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; set_rec(0, 1'b0);
    s_en = 0; s_trig = 0; s_clr = 0; s_rdy = 0;
    t8_en = 0; t8_trig = 0; t8_clr = 0; t8_rdy = 0;
    t0_en = 0; t0_trig = 0; t0_clr = 0; t0_rdy = 0;
    #2;
    chk("rst_s_valid", 136'(s_valid), 136'(0));
    chk("rst_s_count", 136'(s_count), 136'(0));
    chk("rst_t8_frozen", 136'(t8_frozen), 136'(0));
    chk("rst_t0_count", 136'(t0_count), 136'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Stream overflow: 6 pushes into depth 4 with no drain.
    s_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_rec(i, 1'b0); valid = 1'b1;
      if (i < 4) exp_q.push_back(mkrec(i, 1'b0));
      step();
      if (i == 0) begin
        chk("lat_count", 136'(s_count), 136'(1));
        chk("lat_valid", 136'(s_valid), 136'(1));
        chk("lat_data", 136'(s_data[102:0]), 136'(exp_q[0]));
      end
    end
    valid = 1'b0;
    chk("ovf_count", 136'(s_count), 136'(4));
    chk("ovf_cnt", 136'(s_ovf), 136'(2));
    step();
    chk("hold_data", 136'(s_data[102:0]), 136'(exp_q[0]));
    drain(0);
    chk("empty_valid", 136'(s_valid), 136'(0));

    // Stream full with simultaneous push and pop.
    s_clr = 1'b1; step(); s_clr = 1'b0;
    chk("clr_count", 136'(s_count), 136'(0));
    chk("clr_ovf", 136'(s_ovf), 136'(0));
    for (int i = 10; i < 14; i++) begin
      set_rec(i, 1'b0); valid = 1'b1; exp_q.push_back(mkrec(i, 1'b0));
      step();
    end
    e = exp_q.pop_front();
    chk("pp_head", 136'(s_data[102:0]), 136'(e));
    set_rec(14, 1'b0); exp_q.push_back(mkrec(14, 1'b0)); s_rdy = 1'b1;
    step();
    valid = 1'b0; s_rdy = 1'b0;
    chk("pp_count", 136'(s_count), 136'(4));
    chk("pp_ovf", 136'(s_ovf), 136'(0));
    drain(0);
    s_en = 1'b0;

    // Trigger capture: trap on record 10, two post-trigger records.
    t8_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_rec(i, i == 10); valid = 1'b1;
      if (i >= 5 && i <= 12) exp_q.push_back(mkrec(i, i == 10));
      step();
      if (i == 3) begin
        chk("armed_valid", 136'(t8_valid), 136'(0));
        chk("armed_count", 136'(t8_count), 136'(4));
      end
      if (i == 11) chk("post_frozen", 136'(t8_frozen), 136'(0));
      if (i == 12) chk("trig_frozen", 136'(t8_frozen), 136'(1));
    end
    valid = 1'b0; t8_en = 1'b0;
    chk("frz_count", 136'(t8_count), 136'(8));
    chk("frz_valid", 136'(t8_valid), 136'(1));
    t8_trig = 1'b1; step(); t8_trig = 1'b0;
    chk("frz_trig_count", 136'(t8_count), 136'(8));
    drain(1);
    chk("frz_stays", 136'(t8_frozen), 136'(1));

    // PostTrig=0: external trigger freezes directly, later pushes ignored, then clear.
    t0_en = 1'b1;
    for (int i = 40; i < 42; i++) begin
      set_rec(i, 1'b0); valid = 1'b1; step();
    end
    valid = 1'b0;
    chk("t0_count", 136'(t0_count), 136'(2));
    chk("t0_armed", 136'(t0_frozen), 136'(0));
    t0_trig = 1'b1; step(); t0_trig = 1'b0;
    chk("t0_frozen", 136'(t0_frozen), 136'(1));
    chk("t0_valid", 136'(t0_valid), 136'(1));
    for (int i = 42; i < 44; i++) begin
      set_rec(i, 1'b0); valid = 1'b1; step();
    end
    valid = 1'b0;
    chk("t0_ignored", 136'(t0_count), 136'(2));
    chk("t0_ovf", 136'(t0_ovf), 136'(0));
    set_rec(44, 1'b0); valid = 1'b1; t0_clr = 1'b1;
    step();
    t0_clr = 1'b0; valid = 1'b0;
    chk("t0_clr_count", 136'(t0_count), 136'(0));
    chk("t0_clr_frozen", 136'(t0_frozen), 136'(0));
    chk("t0_clr_valid", 136'(t0_valid), 136'(0));
    set_rec(45, 1'b0); valid = 1'b1; step(); valid = 1'b0;
    chk("t0_rearm_count", 136'(t0_count), 136'(1));
    chk("t0_rearm_valid", 136'(t0_valid), 136'(0));
    t0_en = 1'b0;

    // Asynchronous reset in the middle of a stream drain.
    s_en = 1'b1;
    for (int i = 50; i < 53; i++) begin
      set_rec(i, 1'b0); valid = 1'b1; exp_q.push_back(mkrec(i, 1'b0)); step();
    end
    valid = 1'b0; s_rdy = 1'b1;
    e = exp_q.pop_front();
    chk("mid_head", 136'(s_data[102:0]), 136'(e));
    step();
    chk("mid_next", 136'(s_data[102:0]), 136'(exp_q[0]));
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", 136'(s_valid), 136'(0));
    chk("arst_count", 136'(s_count), 136'(0));
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("rel_count", 136'(s_count), 136'(0));
    chk("rel_valid", 136'(s_valid), 136'(0));
    set_rec(60, 1'b0); valid = 1'b1; exp_q.push_back(mkrec(60, 1'b0));
    step();
    valid = 1'b0;
    chk("post_rst_count", 136'(s_count), 136'(1));
    chk("post_rst_valid", 136'(s_valid), 136'(1));
    e = exp_q.pop_front();
    chk("post_rst_data", 136'(s_data[102:0]), 136'(e));
    step();
    s_rdy = 1'b0;
    chk("post_rst_drained", 136'(s_count), 136'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
